pixel_burst_writer: RTL and testbench

Downstream stage of the render controller: converts each edge-triggered pixel-run request (txn_init, offset_addr, color, pixel_count) into AXI4 INCR write bursts into the DDR framebuffer. It returns a single-cycle txn_done when the run is committed. Runs crossing a 4 KB boundary are split into two bursts. AXI error responses are recorded in a sticky flag.

---
 rtl/render_pkg.sv | 20 ++
 rtl/pixel_burst_writer_edge_pulse.sv | 26 ++
 rtl/pixel_burst_writer.sv | 170 +++++++++++++++++
 tb/tb_pixel_burst_writer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// render_pkg: shared writer state, AXI field
// constants and framebuffer geometry.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AW,
        W,
        B,
        DONE
    } wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int PIXEL_BYTES = 4;
    localparam int PAGE_BYTES  = 4096;

endpackage

// File: rtl/pixel_burst_writer_edge_pulse.sv
// edge_pulse: two-flop rising-edge detector,
// one-cycle pulse per low-to-high input change.
module edge_pulse (
    input  logic clk100,
    input  logic resetn,
    input  logic d,
    output logic pulse
);

    logic ff;
    logic ff2;

    // sample the level twice; pulse on new high
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            ff  <= 1'b0;
            ff2 <= 1'b0;
        end else begin
            ff  <= d;
            ff2 <= ff;
        end
    end

    assign pulse = ff & ~ff2;

endmodule

// File: rtl/pixel_burst_writer.sv
// pixel_burst_writer: turns a pixel-run request
// into one or two AXI4 INCR write bursts.
module pixel_burst_writer
    import render_pkg::*;
#(
    parameter int          burst_len = 16,
    parameter logic [31:0] FB_BASE   = 32'h0000_0000
) (
    input  logic        clk100,
    input  logic        resetn,
    input  logic        txn_init,
    output logic        txn_done,
    input  logic [31:0] offset_addr,
    input  logic [11:0] color,
    input  logic [31:0] pixel_count,
    output logic        busy,
    output logic        err,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    localparam logic [31:0] BL32 = 32'(burst_len);

    wr_state_t   state;
    wr_state_t   state_nx;
    logic        pulse;
    logic [7:0]  beat;
    logic [8:0]  rem;
    logic        over_c;
    logic [8:0]  cnt_c;
    logic [31:0] addr_c;
    logic [10:0] room_c;
    logic [8:0]  first_c;

    edge_pulse u_edge (
        .clk100 (clk100),
        .resetn (resetn),
        .d      (txn_init),
        .pulse  (pulse)
    );

    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wstrb   = 4'hF;

    // clamp the run and size the first burst to the page end
    always_comb begin
        over_c  = pixel_count > BL32;
        cnt_c   = over_c ? BL32[8:0] : pixel_count[8:0];
        addr_c  = FB_BASE + (offset_addr << 2);
        room_c  = 11'((13'(PAGE_BYTES) - {1'b0, addr_c[11:0]}) >> 2);
        first_c = ({2'b00, cnt_c} < room_c) ? cnt_c : room_c[8:0];
    end

    // state register
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_nx      = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        txn_done      = 1'b0;
        busy          = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (pulse) begin
                    state_nx = (cnt_c == 9'd0) ? DONE : AW;
                end
            end
            AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_nx = W;
                end
            end
            W: begin
                m_axi_wvalid = 1'b1;
                m_axi_wlast  = (beat == m_axi_awlen);
                if (m_axi_wready && m_axi_wlast) begin
                    state_nx = B;
                end
            end
            B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    state_nx = (rem != 9'd0) ? AW : DONE;
                end
            end
            DONE: begin
                txn_done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // request capture, beat counting, second burst, sticky error
    always_ff @(posedge clk100) begin
        if (!resetn) begin
            m_axi_awaddr <= 32'd0;
            m_axi_awlen  <= 8'd0;
            m_axi_wdata  <= 32'd0;
            beat         <= 8'd0;
            rem          <= 9'd0;
            err          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pulse) begin
                        m_axi_awaddr <= addr_c;
                        m_axi_awlen  <= (first_c == 9'd0) ? 8'd0
                                      : 8'(first_c - 9'd1);
                        m_axi_wdata  <= {20'd0, color};
                        rem          <= cnt_c - first_c;
                        beat         <= 8'd0;
                        if (over_c) begin
                            err <= 1'b1;
                        end
                    end
                end
                W: begin
                    if (m_axi_wready) begin
                        beat <= beat + 8'd1;
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        beat <= 8'd0;
                        if (m_axi_bresp != RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        if (rem != 9'd0) begin
                            m_axi_awaddr <= m_axi_awaddr
                                + ((32'(m_axi_awlen) + 32'd1) << 2);
                            m_axi_awlen  <= 8'(rem - 9'd1);
                            rem          <= 9'd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_burst_writer.sv
// tb_pixel_burst_writer: directed scenarios with
// a small AXI write slave driven from the tasks.
module tb_pixel_burst_writer;

    logic        clk100 = 1'b0;
    logic        resetn;
    logic        txn_init;
    logic        txn_done;
    logic [31:0] offset_addr;
    logic [11:0] color;
    logic [31:0] pixel_count;
    logic        busy;
    logic        err;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    always #5 clk100 = ~clk100;

    pixel_burst_writer #(
        .burst_len (16),
        .FB_BASE   (32'h0000_0000)
    ) dut (
        .clk100        (clk100),
        .resetn        (resetn),
        .txn_init      (txn_init),
        .txn_done      (txn_done),
        .offset_addr   (offset_addr),
        .color         (color),
        .pixel_count   (pixel_count),
        .busy          (busy),
        .err           (err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    int checks = 0;
    int failures = 0;

    int          n_aw;
    logic [31:0] aw_addr [4];
    logic [7:0]  aw_len [4];
    int          n_beats;
    int          wlast_bad;
    int          data_bad;
    int          stall_bad;
    int          proto_bad;
    int          done_cnt;
    int          done_c;
    logic        busy0;
    logic        busy1;
    logic        awv1;
    logic        awv_ever;
    logic        timeout;
    logic        err_pre;
    int          rst_bad;

    task automatic apply_reset();
        @(negedge clk100);
        resetn        = 1'b0;
        txn_init      = 1'b0;
        offset_addr   = 32'd0;
        color         = 12'd0;
        pixel_count   = 32'd0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        @(negedge clk100);
        @(negedge clk100);
        resetn = 1'b1;
    endtask

    task automatic run_txn(
        input logic [31:0] off,
        input logic [11:0] col,
        input logic [31:0] cnt,
        input bit          toggle,
        input logic [1:0]  resp,
        input int          ovl_c,
        input int          rst_beat
    );
        logic        p_awv, p_awr, p_wv, p_wr, p_wlast;
        logic [31:0] p_awaddr, p_wdata;
        logic [7:0]  p_awlen;
        logic        b_arm, b_hs, exp_last;
        int          bib;
        n_aw = 0; n_beats = 0; wlast_bad = 0; data_bad = 0;
        stall_bad = 0; proto_bad = 0; done_cnt = 0; done_c = -1;
        busy0 = 1'bx; busy1 = 1'bx; awv1 = 1'bx;
        awv_ever = 1'b0; timeout = 1'b0; err_pre = 1'b0; rst_bad = 0;
        offset_addr = off; color = col; pixel_count = cnt;
        txn_init = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        @(negedge clk100);
        txn_init = 1'b1;
        @(posedge clk100);
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_wlast = 0;
        p_awaddr = 0; p_wdata = 0; p_awlen = 0;
        b_arm = 0; b_hs = 0; bib = 0;
        for (int c = 0; c <= 300; c++) begin
            @(negedge clk100);
            if (c == 300) begin
                timeout = 1'b1;
                break;
            end
            if (c == 0) busy0 = busy;
            if (c == 1) begin
                busy1 = busy;
                awv1  = m_axi_awvalid;
            end
            if (m_axi_awvalid) awv_ever = 1'b1;
            if (m_axi_awvalid && m_axi_wvalid) proto_bad++;
            if (p_awv && !p_awr && (!m_axi_awvalid
                || m_axi_awaddr !== p_awaddr
                || m_axi_awlen !== p_awlen)) stall_bad++;
            if (p_wv && !p_wr && (!m_axi_wvalid
                || m_axi_wdata !== p_wdata
                || m_axi_wlast !== p_wlast)) stall_bad++;
            if (txn_done) begin
                done_cnt++;
                done_c = c;
            end
            if (c == 1) txn_init = 1'b0;
            if (ovl_c > 0 && c == ovl_c) txn_init = 1'b1;
            if (rst_beat > 0 && n_beats == rst_beat) begin
                err_pre = err;
                resetn = 1'b0;
                m_axi_bvalid = 1'b0;
                m_axi_awready = 1'b0;
                m_axi_wready = 1'b0;
                @(negedge clk100);
                if (m_axi_awvalid || m_axi_wvalid || m_axi_wlast
                    || m_axi_bready || txn_done || busy || err)
                    rst_bad++;
                if (m_axi_awaddr !== 32'd0 || m_axi_awlen !== 8'd0
                    || m_axi_wdata !== 32'd0)
                    rst_bad++;
                resetn = 1'b1;
                break;
            end
            if (done_cnt > 0 && !busy && !txn_done) break;
            if (b_hs) m_axi_bvalid = 1'b0;
            if (b_arm) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = resp;
            end
            b_hs = 1'b0;
            b_arm = 1'b0;
            m_axi_awready = toggle ? (c % 2 == 0) : 1'b1;
            m_axi_wready  = toggle ? (c % 2 == 0) : 1'b1;
            if (m_axi_awvalid && m_axi_awready) begin
                if (n_aw < 4) begin
                    aw_addr[n_aw] = m_axi_awaddr;
                    aw_len[n_aw]  = m_axi_awlen;
                end
                if (m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01)
                    proto_bad++;
                n_aw++;
                bib = 0;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wdata !== {20'd0, col} || m_axi_wstrb !== 4'hF)
                    data_bad++;
                if (n_aw < 1 || n_aw > 4) begin
                    wlast_bad++;
                end else begin
                    exp_last = (bib == int'(aw_len[n_aw-1]));
                    if (m_axi_wlast !== exp_last) wlast_bad++;
                end
                n_beats++;
                bib++;
                if (m_axi_wlast) b_arm = 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) b_hs = 1'b1;
            p_awv = m_axi_awvalid; p_awr = m_axi_awready;
            p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
            p_wv = m_axi_wvalid; p_wr = m_axi_wready;
            p_wdata = m_axi_wdata; p_wlast = m_axi_wlast;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk100);
        checks++;
        if ({txn_done, busy, err, m_axi_awvalid, m_axi_wvalid,
             m_axi_wlast, m_axi_bready} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 0000000",
                {txn_done, busy, err, m_axi_awvalid, m_axi_wvalid,
                 m_axi_wlast, m_axi_bready});
        end
        checks++;
        if (m_axi_awaddr !== 32'd0 || m_axi_awlen !== 8'd0
            || m_axi_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got %h/%h/%h want 0/0/0",
                m_axi_awaddr, m_axi_awlen, m_axi_wdata);
        end
        checks++;
        if (m_axi_awsize !== 3'b010 || m_axi_awburst !== 2'b01
            || m_axi_wstrb !== 4'hF) begin
            failures++;
            $display("FAIL fixed_fields got %b/%b/%h want 010/01/f",
                m_axi_awsize, m_axi_awburst, m_axi_wstrb);
        end
    endtask

    task automatic test_single();
        apply_reset();
        run_txn(32'h10, 12'hABC, 32'd1, 1'b0, 2'b00, 0, 0);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL single_timeout got %b want 0", timeout);
        end
        checks++;
        if ({busy0, busy1, awv1} !== 3'b011) begin
            failures++;
            $display("FAIL single_start got %b want 011",
                {busy0, busy1, awv1});
        end
        checks++;
        if (n_aw !== 1 || aw_addr[0] !== 32'h40 || aw_len[0] !== 8'd0) begin
            failures++;
            $display("FAIL single_aw got n=%0d %h len=%0d want 1 40 0",
                n_aw, aw_addr[0], aw_len[0]);
        end
        checks++;
        if (n_beats !== 1 || data_bad !== 0 || wlast_bad !== 0) begin
            failures++;
            $display("FAIL single_w got beats=%0d dbad=%0d lbad=%0d want 1 0 0",
                n_beats, data_bad, wlast_bad);
        end
        checks++;
        if (done_cnt !== 1 || done_c !== 4) begin
            failures++;
            $display("FAIL single_done got cnt=%0d cyc=%0d want 1 4",
                done_cnt, done_c);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL single_err got %b want 0", err);
        end
    endtask

    task automatic test_burst_backpressure();
        apply_reset();
        run_txn(32'h100, 12'h5A5, 32'd16, 1'b1, 2'b00, 0, 0);
        checks++;
        if (n_aw !== 1 || aw_addr[0] !== 32'h400 || aw_len[0] !== 8'd15) begin
            failures++;
            $display("FAIL bp_aw got n=%0d %h len=%0d want 1 400 15",
                n_aw, aw_addr[0], aw_len[0]);
        end
        checks++;
        if (n_beats !== 16 || wlast_bad !== 0 || data_bad !== 0) begin
            failures++;
            $display("FAIL bp_w got beats=%0d lbad=%0d dbad=%0d want 16 0 0",
                n_beats, wlast_bad, data_bad);
        end
        checks++;
        if (stall_bad !== 0 || proto_bad !== 0) begin
            failures++;
            $display("FAIL bp_stable got stall=%0d proto=%0d want 0 0",
                stall_bad, proto_bad);
        end
        checks++;
        if (done_cnt !== 1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL bp_done got cnt=%0d to=%b want 1 0",
                done_cnt, timeout);
        end
    endtask

    task automatic test_split();
        apply_reset();
        run_txn(32'h3FC, 12'h0F0, 32'd8, 1'b0, 2'b00, 0, 0);
        checks++;
        if (n_aw !== 2 || aw_addr[0] !== 32'hFF0 || aw_len[0] !== 8'd3) begin
            failures++;
            $display("FAIL split_aw0 got n=%0d %h len=%0d want 2 ff0 3",
                n_aw, aw_addr[0], aw_len[0]);
        end
        checks++;
        if (aw_addr[1] !== 32'h1000 || aw_len[1] !== 8'd3) begin
            failures++;
            $display("FAIL split_aw1 got %h len=%0d want 1000 3",
                aw_addr[1], aw_len[1]);
        end
        checks++;
        if (n_beats !== 8 || wlast_bad !== 0 || proto_bad !== 0) begin
            failures++;
            $display("FAIL split_w got beats=%0d lbad=%0d proto=%0d want 8 0 0",
                n_beats, wlast_bad, proto_bad);
        end
        checks++;
        if (done_cnt !== 1 || done_c !== 13) begin
            failures++;
            $display("FAIL split_done got cnt=%0d cyc=%0d want 1 13",
                done_cnt, done_c);
        end
    endtask

    task automatic test_bad_counts();
        apply_reset();
        run_txn(32'h40, 12'h111, 32'd0, 1'b0, 2'b00, 0, 0);
        checks++;
        if (awv_ever !== 1'b0 || done_cnt !== 1 || done_c !== 1) begin
            failures++;
            $display("FAIL zero_cnt got awv=%b cnt=%0d cyc=%0d want 0 1 1",
                awv_ever, done_cnt, done_c);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL zero_err got %b want 0", err);
        end
        run_txn(32'h0, 12'h222, 32'd40, 1'b0, 2'b00, 0, 0);
        checks++;
        if (n_beats !== 16 || aw_len[0] !== 8'd15 || done_cnt !== 1) begin
            failures++;
            $display("FAIL clamp_w got beats=%0d len=%0d cnt=%0d want 16 15 1",
                n_beats, aw_len[0], done_cnt);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL clamp_err got %b want 1", err);
        end
    endtask

    task automatic test_error_overlap();
        int busy_seen;
        apply_reset();
        run_txn(32'h20, 12'hF00, 32'd4, 1'b0, 2'b10, 2, 0);
        checks++;
        if (done_cnt !== 1 || done_c !== 7 || n_aw !== 1) begin
            failures++;
            $display("FAIL ovl_done got cnt=%0d cyc=%0d aw=%0d want 1 7 1",
                done_cnt, done_c, n_aw);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL bresp_err got %b want 1", err);
        end
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk100);
            if (busy || txn_done) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL ovl_drop got busy=%0d err=%b want 0 1",
                busy_seen, err);
        end
        txn_init = 1'b0;
    endtask

    task automatic test_reset_mid_w();
        apply_reset();
        run_txn(32'h200, 12'h777, 32'd40, 1'b0, 2'b00, 0, 5);
        checks++;
        if (err_pre !== 1'b1 || rst_bad !== 0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL midw_reset got pre=%b bad=%0d done=%0d want 1 0 0",
                err_pre, rst_bad, done_cnt);
        end
        run_txn(32'h8, 12'h123, 32'd2, 1'b0, 2'b00, 0, 0);
        checks++;
        if (aw_addr[0] !== 32'h20 || aw_len[0] !== 8'd1
            || n_beats !== 2 || data_bad !== 0) begin
            failures++;
            $display("FAIL after_rst_w got %h len=%0d beats=%0d dbad=%0d want 20 1 2 0",
                aw_addr[0], aw_len[0], n_beats, data_bad);
        end
        checks++;
        if (done_cnt !== 1 || done_c !== 5 || err !== 1'b0) begin
            failures++;
            $display("FAIL after_rst_done got cnt=%0d cyc=%0d err=%b want 1 5 0",
                done_cnt, done_c, err);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_txn(32'h0, 12'h321, 32'd1, 1'b0, 2'b00, 0, 0);
        checks++;
        if (done_cnt !== 1 || aw_addr[0] !== 32'h0) begin
            failures++;
            $display("FAIL b2b_first got cnt=%0d %h want 1 0",
                done_cnt, aw_addr[0]);
        end
        run_txn(32'h4, 12'h321, 32'd1, 1'b0, 2'b00, 0, 0);
        checks++;
        if (done_cnt !== 1 || done_c !== 4 || aw_addr[0] !== 32'h10) begin
            failures++;
            $display("FAIL b2b_second got cnt=%0d cyc=%0d %h want 1 4 10",
                done_cnt, done_c, aw_addr[0]);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        txn_init      = 1'b0;
        offset_addr   = 32'd0;
        color         = 12'd0;
        pixel_count   = 32'd0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        test_reset();
        test_single();
        test_burst_backpressure();
        test_split();
        test_bad_counts();
        test_error_overlap();
        test_reset_mid_w();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
